// File: rtl/ccd_adc_sample_capture_pkg.sv
// ccd_capture_pkg: shared FSM state type, default widths and FIFO entry layout
// for the CCD ADC sample capture block.
package ccd_capture_pkg;
    localparam int DEF_DATA_W = 12;
    localparam int DEF_IDX_W  = 10;
    typedef enum logic [1:0] {IDLE, CONV, SHIFT, PUSH} state_t;
    typedef struct packed {
        logic [DEF_IDX_W-1:0]  index;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/ccd_adc_sample_capture_if.sv
// ccd_adc_sample_capture_if: tagged-sample stream toward the DMA side.
// pix_data/pix_index : FIFO head sample and its pixel index
// pix_valid          : FIFO non-empty
// pix_ready          : consumer pops the head when valid & ready
interface ccd_adc_sample_capture_if
    import ccd_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
);
    logic [DATA_W-1:0] pix_data;
    logic [IDX_W-1:0]  pix_index;
    logic              pix_valid;
    logic              pix_ready;
    modport master (output pix_data, pix_index, pix_valid, input pix_ready);
    modport slave  (input pix_data, pix_index, pix_valid, output pix_ready);
endinterface

// File: rtl/ccd_adc_sample_capture_fifo.sv
// capture_fifo: first-word fall-through FIFO, async active-low reset.
// i_wr_en/i_wr_data : push (accepted when not full, or full with a pop this cycle)
// i_rd_en           : pop the head when non-empty
// o_rd_data         : head entry (0 while empty)
// o_full/o_empty    : occupancy flags
module capture_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_rd, do_wr;
    assign o_empty   = wr_ptr == rd_ptr;
    assign o_full    = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
    assign do_rd     = i_rd_en & ~o_empty;
    assign do_wr     = i_wr_en & (~o_full | do_rd);
    assign o_rd_data = o_empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(do_wr);
            rd_ptr <= rd_ptr + (AW+1)'(do_rd);
        end
    end
    always_ff @(posedge i_clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= i_wr_data;
    end
endmodule

// File: rtl/ccd_adc_sample_capture.sv
// ccd_adc_sample_capture: drives a serial ADC per start strobe, tags each sample
// with its pixel index in the current CCD line and queues it in a FWFT FIFO.
// i_adc_start/i_phi_p : async start-conversion strobe / line-start pulse
// o_adc_cnv/o_adc_sck/i_adc_sdo : serial ADC, MSB first
// pix                 : tagged sample stream (master side)
// o_line_done         : one-cycle pulse on the last pixel of a line
// o_overrun/i_clr_overrun : sticky error flag and its clear
module ccd_adc_sample_capture
    import ccd_capture_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int PIXELS      = 512,
    parameter int CONV_CYCLES = 40,
    parameter int SCK_DIV     = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_adc_start,
    input  logic i_phi_p,
    output logic o_adc_cnv,
    output logic o_adc_sck,
    input  logic i_adc_sdo,
    ccd_adc_sample_capture_if.master pix,
    output logic o_line_done,
    output logic o_overrun,
    input  logic i_clr_overrun
);
    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam int DW = $clog2(SCK_DIV + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(PIXELS - 1);
    // bits [1:0] form the synchroniser, bit 2 holds the previous value for edge detect
    logic [2:0] start_sync, phi_sync;
    logic start_evt, line_evt;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DW-1:0] div, div_n;
    logic [BW-1:0] bits, bits_n;
    logic [DATA_W-1:0] sreg, sreg_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic sck_n, line_full, line_full_n, wr_en, ovr_set, line_done_n, fifo_full, fifo_empty;
    logic [IDX_W+DATA_W-1:0] head;
    assign start_evt = start_sync[1] & ~start_sync[2];
    assign line_evt  = phi_sync[1] & ~phi_sync[2];
    assign o_adc_cnv = state == CONV;
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        div_n       = div;
        bits_n      = bits;
        sck_n       = o_adc_sck;
        sreg_n      = sreg;
        idx_n       = idx;
        line_full_n = line_full;
        wr_en       = 1'b0;
        line_done_n = 1'b0;
        ovr_set     = start_evt & (state != IDLE) & ~line_evt;
        if (line_evt) begin
            state_n     = IDLE;
            sck_n       = 1'b0;
            idx_n       = '0;
            line_full_n = 1'b0;
        end else begin
            case (state)
                IDLE: if (start_evt && i_enable) begin
                    state_n = CONV;
                    cnt_n   = CW'(CONV_CYCLES - 1);
                end
                CONV: if (cnt == '0) begin
                    state_n = SHIFT;
                    bits_n  = BW'(DATA_W);
                    div_n   = DW'(SCK_DIV - 1);
                end else cnt_n = cnt - CW'(1);
                SHIFT: if (div != '0) div_n = div - DW'(1);
                else begin
                    div_n = DW'(SCK_DIV - 1);
                    sck_n = ~o_adc_sck;
                    // data is captured on the edge that drives SCK high; the falling edge after the last bit ends the frame
                    if (!o_adc_sck) begin
                        sreg_n = {sreg[DATA_W-2:0], i_adc_sdo};
                        bits_n = bits - BW'(1);
                    end else if (bits == '0) state_n = PUSH;
                end
                PUSH: begin
                    state_n     = IDLE;
                    wr_en       = ~fifo_full | pix.pix_ready;
                    ovr_set     = ovr_set | (fifo_full & ~pix.pix_ready) | line_full;
                    line_done_n = (idx == LAST) & ~line_full;
                    if (idx == LAST) line_full_n = 1'b1;
                    else idx_n = idx + IDX_W'(1);
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            start_sync  <= '0;
            phi_sync    <= '0;
            state       <= IDLE;
            cnt         <= '0;
            div         <= '0;
            bits        <= '0;
            o_adc_sck   <= 1'b0;
            sreg        <= '0;
            idx         <= '0;
            line_full   <= 1'b0;
            o_line_done <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            start_sync  <= {start_sync[1:0], i_adc_start};
            phi_sync    <= {phi_sync[1:0], i_phi_p};
            state       <= state_n;
            cnt         <= cnt_n;
            div         <= div_n;
            bits        <= bits_n;
            o_adc_sck   <= sck_n;
            sreg        <= sreg_n;
            idx         <= idx_n;
            line_full   <= line_full_n;
            o_line_done <= line_done_n;
            o_overrun   <= ovr_set | (o_overrun & ~i_clr_overrun);
        end
    end
    capture_fifo #(.WIDTH(IDX_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (wr_en),
        .i_wr_data ({idx, sreg}),
        .i_rd_en   (pix.pix_ready),
        .o_rd_data (head),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty)
    );
    assign {pix.pix_index, pix.pix_data} = head;
    assign pix.pix_valid = ~fifo_empty;
endmodule
